// File: rtl/regression_coefficient_engine.sv
// Streaming least-squares line fitter. It accumulates N=2^LOG2_N (x,y) pairs, then derives slope b_1
// with a restoring bit-serial divider and intercept b_0 in signed fixed point.
module regression_coefficient_engine #(
  parameter int W      = 20,
  parameter int LOG2_N = 7,
  parameter int FRAC   = 8,
  parameter int OUT_W  = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x_in,
  input  logic [W-1:0]     y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] b_0,
  output logic [OUT_W-1:0] b_1,
  output logic             singular,
  output logic             sat,
  output logic             busy,
  output logic [2:0]       dbg_state
);
  localparam int N  = 1 << LOG2_N;
  localparam int SW = W + LOG2_N;
  localparam int PW = 2*W + LOG2_N;
  localparam int NW = 2*W + 2*LOG2_N + 2;
  localparam int DW = 2*W + 2*LOG2_N + FRAC;  // quotient bits == divide cycles
  localparam int CW = $clog2(DW + 1);
  localparam int IW = SW + OUT_W + FRAC + 2;
  localparam logic signed [DW:0]   Q_MAX = {{(DW-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [DW:0]   Q_MIN = ~Q_MAX;
  localparam logic signed [IW-1:0] I_MAX = {{(IW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IW-1:0] I_MIN = ~I_MAX;

  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_PREP, S_DIVIDE, S_INTERCEPT, S_DONE} state_t;
  state_t state_q, state_d;

  logic signed [SW-1:0] sx_q, sy_q;
  logic signed [PW-1:0] sxx_q, sxy_q;
  logic [LOG2_N-1:0]    cnt_q;
  logic [NW-2:0]        rem_q;
  logic [DW-1:0]        quo_q;
  logic [NW-1:0]        den_q;
  logic                 neg_q;
  logic [CW-1:0]        dcnt_q;
  logic [OUT_W-1:0]     b0_q, b1_q;
  logic                 sing_q, sat_q;

  logic signed [W-1:0]     xs, ys;
  logic                    accept, last_sample;
  logic signed [NW-1:0]    num_w;
  logic [NW-1:0]           den_w, abs_num;
  logic [DW-1:0]           dividend;
  logic [NW-1:0]           rem_sh;
  logic                    q_bit;
  logic [NW-2:0]           rem_d;
  logic signed [DW:0]      q_signed;
  logic signed [OUT_W-1:0] b1_w, b0_w;
  logic                    b1_clamp, b0_clamp;
  logic signed [IW-1:0]    t_w, b0_full;

  // Input handshake: a sample transfers on a rising edge where in_valid & in_ready; in_ready is high
  // only in ACCUM. Output handshake: a result transfers where out_valid & out_ready.
  assign xs          = x_in;
  assign ys          = y_in;
  assign accept      = in_valid && (state_q == S_ACCUM);
  assign last_sample = accept && (cnt_q == LOG2_N'(N - 1));

  assign num_w    = (NW'(sxy_q) <<< LOG2_N) - NW'(sx_q) * NW'(sy_q);
  assign den_w    = (NW'(sxx_q) <<< LOG2_N) - NW'(sx_q) * NW'(sx_q);
  assign abs_num  = num_w[NW-1] ? -num_w : num_w;
  assign dividend = DW'((NW+FRAC)'(abs_num) << FRAC);

  assign rem_sh = {rem_q, quo_q[DW-1]};
  assign q_bit  = (rem_sh >= den_q);
  assign rem_d  = q_bit ? (NW-1)'(rem_sh - den_q) : rem_sh[NW-2:0];

  always_comb begin
    q_signed = neg_q ? -$signed({1'b0, quo_q}) : $signed({1'b0, quo_q});
    b1_clamp = 1'b0;
    b1_w     = OUT_W'(q_signed);
    if (q_signed > Q_MAX) begin
      b1_w     = OUT_W'(Q_MAX);
      b1_clamp = 1'b1;
    end else if (q_signed < Q_MIN) begin
      b1_w     = OUT_W'(Q_MIN);
      b1_clamp = 1'b1;
    end
    // A singular fit leaves quo_q at zero, so this also yields mean(y) in that case.
    t_w      = (IW'(sy_q) <<< FRAC) - IW'(b1_w) * IW'(sx_q);
    b0_full  = t_w >>> LOG2_N;
    b0_clamp = 1'b0;
    b0_w     = OUT_W'(b0_full);
    if (b0_full > I_MAX) begin
      b0_w     = OUT_W'(I_MAX);
      b0_clamp = 1'b1;
    end else if (b0_full < I_MIN) begin
      b0_w     = OUT_W'(I_MIN);
      b0_clamp = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start) state_d = S_ACCUM;
      S_ACCUM:     if (last_sample) state_d = S_PREP;
      S_PREP:      state_d = (den_w == '0) ? S_INTERCEPT : S_DIVIDE;
      S_DIVIDE:    if (dcnt_q == CW'(DW - 1)) state_d = S_INTERCEPT;
      S_INTERCEPT: state_d = S_DONE;
      S_DONE:      if (out_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_ACCUM);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
    b_0       = b0_q;
    b_1       = b1_q;
    singular  = sing_q;
    sat       = sat_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sx_q <= '0; sy_q <= '0; sxx_q <= '0; sxy_q <= '0; cnt_q <= '0;
      rem_q <= '0; quo_q <= '0; den_q <= '0; neg_q <= 1'b0; dcnt_q <= '0;
      b0_q <= '0; b1_q <= '0; sing_q <= 1'b0; sat_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          sx_q <= '0; sy_q <= '0; sxx_q <= '0; sxy_q <= '0; cnt_q <= '0;
        end
        S_ACCUM: if (accept) begin
          sx_q  <= sx_q + SW'(xs);
          sy_q  <= sy_q + SW'(ys);
          sxx_q <= sxx_q + PW'(xs) * PW'(xs);
          sxy_q <= sxy_q + PW'(xs) * PW'(ys);
          cnt_q <= cnt_q + LOG2_N'(1);
        end
        S_PREP: begin
          den_q  <= den_w;
          neg_q  <= num_w[NW-1];
          rem_q  <= '0;
          dcnt_q <= '0;
          quo_q  <= (den_w == '0) ? '0 : dividend;
        end
        S_DIVIDE: begin
          quo_q  <= {quo_q[DW-2:0], q_bit};
          rem_q  <= rem_d;
          dcnt_q <= dcnt_q + CW'(1);
        end
        S_INTERCEPT: begin
          b1_q   <= b1_w;
          b0_q   <= b0_w;
          sing_q <= (den_q == '0);
          sat_q  <= b1_clamp | b0_clamp;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_regression_coefficient_engine.sv
// Bench for regression_coefficient_engine: directed scenarios plus random fits against an arithmetic model.
module tb_regression_coefficient_engine;
  localparam int W = 8, L = 2, FRAC = 4, OUT_W = 12, N = 4;
  localparam int DIV_CYC = 2*W + 2*L + FRAC;
  localparam longint B_MAX = (64'sd1 <<< (OUT_W-1)) - 1;
  localparam longint B_MIN = -(64'sd1 <<< (OUT_W-1));

  logic clk = 1'b0;
  logic reset, start, in_valid, out_ready;
  logic [W-1:0] x_in, y_in;
  logic in_ready, out_valid, singular, sat, busy;
  logic [OUT_W-1:0] b_0, b_1;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fails = 0;
  int smp_x[N], smp_y[N];
  longint exp_b0, exp_b1;
  bit exp_sing, exp_sat;

  regression_coefficient_engine #(.W(W), .LOG2_N(L), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .b_0(b_0), .b_1(b_1), .singular(singular), .sat(sat), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Least-squares reference from the closed-form sums.
  function automatic void model();
    longint sx = 0, sy = 0, sxx = 0, sxy = 0, num, den, q, t, b0;
    for (int i = 0; i < N; i++) begin
      sx += smp_x[i]; sy += smp_y[i];
      sxx += longint'(smp_x[i]) * smp_x[i];
      sxy += longint'(smp_x[i]) * smp_y[i];
    end
    num = N * sxy - sx * sy;
    den = N * sxx - sx * sx;
    exp_sing = (den == 0);
    exp_sat = 1'b0;
    if (den == 0) q = 0;
    else begin
      q = ((num < 0 ? -num : num) * (64'sd1 <<< FRAC)) / den;
      if (num < 0) q = -q;
    end
    if (q > B_MAX) begin q = B_MAX; exp_sat = 1'b1; end
    else if (q < B_MIN) begin q = B_MIN; exp_sat = 1'b1; end
    exp_b1 = q;
    t = sy * (64'sd1 <<< FRAC) - q * sx;
    b0 = (t - (((t % N) + N) % N)) / N;
    if (b0 > B_MAX) begin b0 = B_MAX; exp_sat = 1'b1; end
    else if (b0 < B_MIN) begin b0 = B_MIN; exp_sat = 1'b1; end
    exp_b0 = b0;
  endfunction

  task automatic set4(input int x0, x1, x2, x3, y0, y1, y2, y3);
    smp_x[0] = x0; smp_x[1] = x1; smp_x[2] = x2; smp_x[3] = x3;
    smp_y[0] = y0; smp_y[1] = y1; smp_y[2] = y2; smp_y[3] = y3;
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle before each sample, 2 random 0..2 idle cycles.
  task automatic send_samples(input int gap_mode);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < N; i++) begin
      int g;
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      in_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      x_in = W'(smp_x[i]);
      y_in = W'(smp_y[i]);
      check("in_ready_accum", in_ready, 1);
      @(posedge clk); #1;
    end
    x_in = W'($urandom);
    y_in = W'($urandom);
    check("in_ready_after_last", in_ready, 0);
  endtask

  task automatic do_fit(input int gap_mode, input int hold);
    int cyc;
    model();
    send_samples(gap_mode);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", cyc, exp_sing ? 2 : DIV_CYC + 2);
    check("b_1", $signed(b_1), exp_b1);
    check("b_0", $signed(b_0), exp_b0);
    check("singular", singular, exp_sing);
    check("sat", sat, exp_sat);
    for (int k = 0; k < hold; k++) begin
      start = k[0];
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_b_1", $signed(b_1), exp_b1);
      check("hold_b_0", $signed(b_0), exp_b0);
    end
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    check("out_valid_after_take", out_valid, 0);
    check("busy_after_take", busy, 0);
    check("b_0_held", $signed(b_0), exp_b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_b_0", b_0, 0);
    check("rst_b_1", b_1, 0);
    check("rst_singular", singular, 0);
    check("rst_sat", sat, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    set4(1, 2, 3, 4, 3, 5, 7, 9);
    do_fit(0, 0);
    check("line_b_1", $signed(b_1), 32);
    check("line_b_0", $signed(b_0), 16);

    set4(1, 2, 3, 4, 4, 2, 0, -2);
    do_fit(1, 0);
    check("neg_b_1", $signed(b_1), -32);
    check("neg_b_0", $signed(b_0), 96);

    set4(5, 5, 5, 5, 1, 2, 3, 4);
    do_fit(2, 0);
    check("sing_flag", singular, 1);
    check("sing_b_1", $signed(b_1), 0);
    check("sing_b_0", $signed(b_0), 40);

    set4(0, 0, 0, 1, -128, -128, -128, 127);
    do_fit(0, 0);
    check("sat_b_1", $signed(b_1), 2047);
    check("sat_b_0", $signed(b_0), -1540);
    check("sat_flag", sat, 1);

    set4(1, 2, 3, 4, 3, 5, 7, 9);
    do_fit(0, 10);

    set4(1, 2, 3, 4, 4, 2, 0, -2);
    send_samples(0);
    in_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_b_0", b_0, 0);
    check("mid_rst_b_1", b_1, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_sat", sat, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst_out_valid", out_valid, 0);
    set4(1, 2, 3, 4, 3, 5, 7, 9);
    do_fit(0, 0);
    check("post_rst_b_1", $signed(b_1), 32);
    check("post_rst_b_0", $signed(b_0), 16);

    for (int r = 0; r < 8; r++) begin
      int xc;
      xc = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < N; i++) begin
        smp_x[i] = (r == 3) ? xc : int'($urandom_range(0, 255)) - 128;
        smp_y[i] = int'($urandom_range(0, 255)) - 128;
      end
      do_fit(2, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/regression_coefficient_engine.md
Name: regression_coefficient_engine

Overview:
Streaming least-squares line fitter: accepts N = 2^LOG2_N signed (x, y) sample pairs over a valid/ready handshake and accumulates Sx, Sy, Sxx and Sxy. It then computes slope b_1 and intercept b_0 in signed fixed point using a bit-serial divider. Results are presented on a valid/ready output with singular and saturation flags. It replaces the fixed-width, fixed-count coefficient calculator and feeds the error-checker stage.

Parameters:
W, 20, sample width (signed two's complement x and y)
LOG2_N, 7, log2 of samples per fit (N = 128)
FRAC, 8, fractional bits of b_0 and b_1
OUT_W, 20, total width of b_0 and b_1 (signed, includes FRAC)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle request to begin a fit; honoured only in IDLE
in_valid  in  1  sample present on x_in/y_in
in_ready  out  1  engine accepts a sample this cycle
x_in  in  W  signed x sample
y_in  in  W  signed y sample
out_valid  out  1  b_0/b_1/flags valid
out_ready  in  1  consumer accepts the result
b_0  out  OUT_W  intercept, signed, FRAC fractional bits
b_1  out  OUT_W  slope, signed, FRAC fractional bits
singular  out  1  denominator was zero (all x equal)
sat  out  1  b_0 or b_1 was clamped
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; all accumulators, counter and divider registers 0; outputs in_ready=0, out_valid=0, b_0=0, b_1=0, singular=0, sat=0, busy=0. Reset mid-operation aborts the fit; no partial result is emitted.
- States: IDLE -> ACCUM (start=1) -> PREP (Nth sample accepted) -> DIVIDE (DIV_CYC = 2W+2*LOG2_N+FRAC cycles) -> INTERCEPT (1 cycle) -> DONE -> IDLE (out_valid & out_ready).
- IDLE: start clears accumulators and counter. start in any other state is ignored.
- ACCUM: in_ready=1. A sample is accepted on a cycle with in_valid & in_ready. Each accepted sample adds x, y, x*x and x*y into full-precision signed accumulators: sums W+LOG2_N bits, products 2W+LOG2_N bits; no overflow is possible. The counter wraps at N, and the transition to PREP occurs on the Nth accepted sample. in_valid=0 stalls accumulation with no penalty.
- PREP: num = (Sxy<<LOG2_N) - Sx*Sy; den = (Sxx<<LOG2_N) - Sx*Sx, which is always >= 0. The divider is loaded with dividend |num|<<FRAC and divisor den, and the sign of num is stored.
- If den==0: skip DIVIDE, set singular=1 and b_1=0.
- DIVIDE: restoring division producing one quotient bit per cycle, MSB first. The quotient is truncated toward zero and the stored sign is then applied.
- Saturation: if the signed quotient lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1], clamp it and set sat=1.
- INTERCEPT: b_0 = ((Sy<<FRAC) - b_1*Sx) >>> LOG2_N, using an arithmetic shift (floor). The intermediate is full precision; b_0 is clamped to OUT_W with sat=1 on clamp. When singular, the same formula gives b_0 = mean(y).
- DONE: out_valid=1. b_0, b_1, singular and sat are stable while out_valid=1 and out_ready=0. The handshake completes on out_valid & out_ready, after which out_valid drops the next cycle. Outputs hold their last values until the next result.
- Latency: out_valid rises DIV_CYC+2 cycles after the edge accepting the Nth sample, or 2 cycles if singular. No new fit can start until the result is taken; start coinciding with the out_ready handshake is ignored.

Test Plan:
All scenarios use W=8, LOG2_N=2, FRAC=4, OUT_W=12.
- Line fit: start, samples (1,3),(2,5),(3,7),(4,9) -> b_1=32 (2.0), b_0=16 (1.0), singular=0, sat=0; out_valid exactly 2*8+4+4+2=26 cycles after the 4th accept.
- Negative slope with in_valid gaps (alternating 0/1): (1,4),(2,2),(3,0),(4,-2) -> b_1=-32, b_0=96 (6.0); exactly 4 samples accepted, in_ready=0 after the 4th.
- Singular: x all 5, y=1,2,3,4 -> singular=1, b_1=0, b_0=40 (2.5), out_valid 2 cycles after the 4th accept.
- Saturation: x=(0,0,0,1), y=(-128,-128,-128,127) -> b_1=2047 (clamped), b_0=-1540, sat=1.
- Output backpressure: hold out_ready=0 for 10 cycles -> out_valid, b_0 and b_1 stable; start pulses ignored; after out_ready=1, out_valid falls next cycle and busy=0.
- Reset mid-DIVIDE: assert reset 5 cycles into DIVIDE -> all outputs 0 immediately. A new fit of scenario 1 then yields b_1=32, b_0=16.
